run_event_logger: RTL and testbench

Downstream consumer of the sequence detector's Mealy output `z`. It turns the level-style detection signal into discrete run events and keeps per-type run counts in two-digit BCD. A run is four or more equal consecutive bits of `w`. It also tracks the current and longest run lengths and drives a retriggerable LED strobe. It runs on the same divided clock `clke` and samples `z` and `w` on the same edge the detector's state register uses.

---
 rtl/run_event_logger.sv | 137 +++++++++++++
 tb/tb_run_event_logger.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/run_event_logger.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | run_event_logger: turns detector level output z into counted run events |
// |   with BCD per-type counts, run length tracking and a retriggerable LED |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module run_event_logger #(
  parameter int unsigned LED_HOLD = 8
) (
  input  logic       clke,
  input  logic       rst,
  input  logic       z,
  input  logic       w,
  input  logic       clr,
  output logic [7:0] zero_runs,
  output logic [7:0] one_runs,
  output logic [7:0] run_len,
  output logic [7:0] max_len,
  output logic       run_type,
  output logic       led
);

  localparam logic [7:0] C_LED_HOLD = 8'(LED_HOLD);
  localparam logic [7:0] C_RUN_START = 8'd4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_RUN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] zero_runs_q, zero_runs_d;
  logic [7:0] one_runs_q, one_runs_d;
  logic [7:0] run_len_q, run_len_d;
  logic [7:0] max_len_q, max_len_d;
  logic       run_type_q, run_type_d;
  logic [7:0] led_cnt_q, led_cnt_d;
  logic       led_q, led_d;

  logic       is_event;
  logic       len_wr;
  logic [7:0] len_new;

  // Two-digit BCD increment; 99 wraps to 00, out-of-range digits fold to 0.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] units;
    logic [3:0] tens;
    units = v[3:0];
    tens  = v[7:4];
    if (units >= 4'd9) begin
      units = 4'd0;
      tens  = (tens >= 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  always_comb begin
    state_d     = state_q;
    zero_runs_d = zero_runs_q;
    one_runs_d  = one_runs_q;
    run_len_d   = run_len_q;
    max_len_d   = max_len_q;
    run_type_d  = run_type_q;
    led_cnt_d   = led_cnt_q;
    len_wr      = 1'b0;
    len_new     = run_len_q;

    // A type change while z stays high is treated as a fresh run.
    is_event = z && ((state_q == IDLE) || (w != run_type_q));
    state_d  = z ? IN_RUN : IDLE;

    if (is_event) begin
      run_type_d = w;
      led_cnt_d  = C_LED_HOLD;
    end else if (led_cnt_q != 8'd0) begin
      led_cnt_d = led_cnt_q - 8'd1;
    end
    led_d = (led_cnt_q != 8'd0);

    if (clr) begin
      zero_runs_d = 8'd0;
      one_runs_d  = 8'd0;
      run_len_d   = 8'd0;
      max_len_d   = 8'd0;
    end else begin
      if (is_event) begin
        if (w) begin
          one_runs_d = bcd_inc(one_runs_q);
        end else begin
          zero_runs_d = bcd_inc(zero_runs_q);
        end
        len_wr  = 1'b1;
        len_new = C_RUN_START;
      end else if ((state_q == IN_RUN) && z) begin
        len_wr  = 1'b1;
        len_new = (run_len_q == 8'hFF) ? 8'hFF : run_len_q + 8'd1;
      end
      if (len_wr) begin
        run_len_d = len_new;
        max_len_d = (len_new > max_len_q) ? len_new : max_len_q;
      end
    end
  end

  always_ff @(posedge clke) begin
    if (rst) begin
      state_q     <= IDLE;
      zero_runs_q <= 8'd0;
      one_runs_q  <= 8'd0;
      run_len_q   <= 8'd0;
      max_len_q   <= 8'd0;
      run_type_q  <= 1'b0;
      led_cnt_q   <= 8'd0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_runs_q <= zero_runs_d;
      one_runs_q  <= one_runs_d;
      run_len_q   <= run_len_d;
      max_len_q   <= max_len_d;
      run_type_q  <= run_type_d;
      led_cnt_q   <= led_cnt_d;
      led_q       <= led_d;
    end
  end

  assign zero_runs = zero_runs_q;
  assign one_runs  = one_runs_q;
  assign run_len   = run_len_q;
  assign max_len   = max_len_q;
  assign run_type  = run_type_q;
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_run_event_logger.sv
`default_nettype none
// Testbench for run_event_logger: vector table, directed corner sequences and
// randomized stimulus compared against an event-level reference model.
module tb_run_event_logger;

  localparam int HOLD = 8;

  logic       clke = 1'b0;
  logic       rst = 1'b1;
  logic       z = 1'b0;
  logic       w = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] zero_runs, one_runs, run_len, max_len;
  logic       run_type, led;

  run_event_logger #(.LED_HOLD(HOLD)) dut (
    .clke(clke), .rst(rst), .z(z), .w(w), .clr(clr),
    .zero_runs(zero_runs), .one_runs(one_runs), .run_len(run_len),
    .max_len(max_len), .run_type(run_type), .led(led)
  );

  always #5 clke = ~clke;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: counts as decimal integers, LED from event timestamps.
  int m_zero, m_one, m_len, m_max, m_cyc, m_last_evt, m_prev_evt;
  bit m_type, m_inrun;

  // Serial-detector emulation used to produce z from a w stream.
  bit d_last;
  int d_eq;

  typedef struct {
    logic z, w, clr;
    logic [7:0] zr, onr, len, mx;
    logic typ, ld;
  } vec_t;
  vec_t tbl[13];

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic bit led_window(input int d);
    return (d >= 1) && (d <= HOLD);
  endfunction

  function automatic logic [33:0] dut_vec();
    return {zero_runs, one_runs, run_len, max_len, run_type, led};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_zero = 0; m_one = 0; m_len = 0; m_max = 0; m_type = 0; m_inrun = 0;
    m_last_evt = -1000; m_prev_evt = -1000;
  endtask

  task automatic model_edge(input bit zi, input bit wi, input bit ci, input bit ri);
    bit ev;
    m_cyc++;
    if (ri) begin
      model_reset();
      return;
    end
    ev = zi && (!m_inrun || (wi != m_type));
    if (ev) begin
      m_type = wi;
      m_prev_evt = m_last_evt;
      m_last_evt = m_cyc;
    end
    if (ci) begin
      m_zero = 0; m_one = 0; m_len = 0; m_max = 0;
    end else if (ev) begin
      if (wi) m_one = (m_one + 1) % 100;
      else    m_zero = (m_zero + 1) % 100;
      m_len = 4;
      if (m_len > m_max) m_max = m_len;
    end else if (m_inrun && zi) begin
      m_len = (m_len >= 255) ? 255 : m_len + 1;
      if (m_len > m_max) m_max = m_len;
    end
    m_inrun = zi;
  endtask

  function automatic logic [33:0] model_vec();
    bit l;
    l = led_window(m_cyc - m_last_evt) || led_window(m_cyc - m_prev_evt);
    return {to_bcd(m_zero), to_bcd(m_one), 8'(m_len), 8'(m_max), m_type, l};
  endfunction

  task automatic step(input bit zi, input bit wi, input bit ci, input bit ri);
    z = zi; w = wi; clr = ci; rst = ri;
    @(posedge clke);
    #1;
    model_edge(zi, wi, ci, ri);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    d_eq = 0; d_last = 1'b0;
  endtask

  task automatic send(input bit wb, input bit ci);
    if (d_eq != 0 && wb == d_last) d_eq = (d_eq >= 1000) ? 1000 : d_eq + 1;
    else d_eq = 1;
    d_last = wb;
    step(d_eq >= 4, wb, ci, 1'b0);
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    d_eq = 0; d_last = 1'b0;
    //              z  w  clr  zr     one    len    max    typ led
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'd4, 8'd4, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'd5, 8'd5, 1'b0, 1'b0};

    do_reset();
    check("reset_state", dut_vec(), 34'd0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].z, tbl[i].w, tbl[i].clr, 1'b0);
      check($sformatf("table_row%0d", i), dut_vec(),
            {tbl[i].zr, tbl[i].onr, tbl[i].len, tbl[i].mx, tbl[i].typ, tbl[i].ld});
    end

    // Two one-runs separated by a single zero.
    do_reset();
    begin
      bit seq[15] = '{1,1,1,1,0,1,1,1,1,1,1,0,0,0,0};
      for (int i = 0; i < 11; i++) send(seq[i], 1'b0);
    end
    check("two_one_runs", {one_runs, run_len, max_len, run_type}, {8'h02, 8'd6, 8'd6, 1'b1});

    // BCD wrap across 100 zero-runs.
    do_reset();
    send(1'b1, 1'b0);
    for (int r = 1; r <= 100; r++) begin
      for (int k = 0; k < 4; k++) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      if (r == 99) check("bcd_99", {zero_runs, one_runs}, {8'h99, 8'h00});
      if (r == 100) check("bcd_wrap", {zero_runs, one_runs}, {8'h00, 8'h00});
    end

    // Length saturation.
    do_reset();
    for (int i = 0; i < 300; i++) send(1'b1, 1'b0);
    check("len_saturate", {run_len, max_len, one_runs}, {8'd255, 8'd255, 8'h01});

    // clr on the event edge suppresses counting of that run.
    do_reset();
    send(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check("clr_on_event", {zero_runs, one_runs, run_len, max_len}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      check("clr_run_uncounted", {24'd0, one_runs}, 32'd0);
    end
    send(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    check("after_clr_run", {24'd0, one_runs}, {24'd0, 8'h01});

    // LED retrigger: events three cycles apart keep the strobe high.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("led_retrig_a", {33'd0, led}, {33'd0, 1'b1});
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("led_retrig_k%0d", k), {33'd0, led}, {33'd0, (k <= 8) ? 1'b1 : 1'b0});
    end

    // Randomized stream, including occasional clr, rst and forced z.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit wb, ci, zf;
      wb = ($urandom_range(0, 99) < 75) ? d_last : ~d_last;
      ci = ($urandom_range(0, 59) == 0);
      zf = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        step(1'b1, wb, ci, 1'b1);
        d_eq = 0;
      end else if (zf) begin
        d_eq = (wb == d_last) ? d_eq + 1 : 1;
        d_last = wb;
        step(1'b1, wb, ci, 1'b0);
      end else begin
        send(wb, ci);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
